reset_run_sequencer: RTL
========================

// Module: reset_run_sequencer
// PURPOSE
//  Parametrised reset/run controller that sits between the board (or bench) reset and the processor datapath.
//  Synchronises an async active-low reset and releases N_CH active-high channel resets in a staggered order
//  (e.g. memories, RF, PC). It then supervises the run: counts executed cycles, detects a halt request or a
//  cycle-limit timeout, and supports a synchronous restart without toggling the external reset.
// PARAMETERS
//  N_CH         3     number of channel reset outputs (>=1)
//  SYNC_STAGES  2     reset-deassertion synchroniser depth (>=2)
//  HOLD_CYCLES  4     cycles all channels stay in reset after synchronised release (>=1)
//  STEP_CYCLES  2     cycles between consecutive channel releases (0 = all release together)
//  CNT_W        32    width of cycle_count
//  MAX_CYCLES   1000  run-cycle limit; 0 disables timeout (must be < 2**CNT_W)
// PORTS
//  Clk          in   1      system clock, rising edge
//  Reset        in   1      asynchronous, active-LOW reset
//  restart      in   1      sync pulse: re-run full release sequence
//  halt         in   1      sync level from processor: program finished
//  rst_out      out  N_CH   active-high channel resets; bit k released k-th
//  run_active   out  1      high while in RUN
//  done         out  1      high in DONE
//  timeout      out  1      high in DONE when entered by cycle limit
//  cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE
// BEHAVIOUR
//  - Reset low: immediately (async) rst_out=all 1, run_active=0, done=0, timeout=0, cycle_count=0,
//    synchroniser cleared, state=ASSERT. Reset low mid-sequence or mid-run aborts instantly to this state.
//  - Reset rise: internal rst_sync goes high on the SYNC_STAGES-th rising Clk edge; assertion never waits.
//  - FSM states: ASSERT -> RELEASE -> RUN -> DONE.
//  - ASSERT: after rst_sync is high, count HOLD_CYCLES edges; on the HOLD_CYCLES-th edge rst_out[0] <= 0
//    and go to RELEASE.
//  - RELEASE: rst_out[k] <= 0 exactly k*STEP_CYCLES edges after rst_out[0] fell. A released bit never
//    re-asserts except via Reset or restart.
//    - Edge after rst_out[N_CH-1] falls: state=RUN, run_active=1, cycle_count=0.
//    - N_CH=1 or STEP_CYCLES=0: RUN is entered the edge after rst_out[0] falls.
//  - RUN: cycle_count += 1 each edge.
//    - halt sampled high: state=DONE, done=1, timeout=0, count not incremented that edge.
//    - MAX_CYCLES!=0 and the increment makes cycle_count==MAX_CYCLES: count takes that value,
//      state=DONE, done=1, timeout=1.
//    - halt and timeout on the same edge: halt wins (timeout=0).
//    - MAX_CYCLES=0: count saturates at all-ones; never wraps.
//  - DONE: all outputs held; rst_out stays 0; halt ignored.
//  - restart (any state except ASSERT with rst_sync low):
//    - next edge: rst_out=all 1, run_active=0, done=0, timeout=0, cycle_count=0, state=ASSERT, hold counter reset.
//    - restart beats halt/timeout on the same edge; restart in ASSERT restarts the hold count.
//  - halt in ASSERT/RELEASE ignored. No combinational input->output paths; all outputs are registered.
// TESTING (defaults; E0 = first rising edge after Reset goes high)
//  - Release order: Reset low 3 cycles, then high -> rst_out 3'b111 through E4; 3'b110 at E5;
//    3'b100 at E7; 3'b000 at E9; run_active=1 at E10, cycle_count=0, then 1,2,3...
//  - Halt: assert halt when cycle_count=25 -> next edge done=1, timeout=0, cycle_count stays 25;
//    toggling halt afterwards has no effect.
//  - Timeout: halt tied low -> cycle_count reaches 1000, done=1, timeout=1 on that edge; count frozen at 1000.
//  - Tie: MAX_CYCLES=10; halt high on the edge count would reach 10 -> done=1, timeout=0, count=9.
//  - Restart: pulse restart in DONE -> next edge rst_out=3'b111, flags 0; release pattern repeats
//    with the same spacing (no sync delay); pulse restart together with halt in RUN -> restart wins.
//  - Async abort: drop Reset mid-RELEASE (rst_out=3'b110) between clock edges -> rst_out=3'b111
//    with no clock edge; release restarts from the sync stage.

Source files
------------

// File: rtl/reset_run_sequencer.sv
// rtl/reset_run_sequencer.sv - staggered channel reset release and run supervisor
module reset_run_sequencer #(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STEP_CYCLES = 2,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             restart,
    input  logic             halt,
    output logic [N_CH-1:0]  rst_out,
    output logic             run_active,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HOLD_LAST = HOLD_CYCLES - 1;
    localparam int STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int STEP_LAST = (STEP_CYCLES > 0) ? STEP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {ASSERT, RELEASE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rst_sync;
    logic [HOLD_W-1:0]      hold_cnt, hold_cnt_nxt;
    logic [STEP_W-1:0]      step_cnt, step_cnt_nxt;
    logic [N_CH-1:0]        rst_out_nxt;
    logic                   run_active_nxt, done_nxt, timeout_nxt;
    logic [CNT_W-1:0]       cycle_count_nxt, cnt_inc;

    // Deassertion-only synchroniser; assertion is immediate through the async clear.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_sync = sync[SYNC_STAGES-1];

    assign cnt_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ASSERT;
            hold_cnt    <= '0;
            step_cnt    <= '0;
            rst_out     <= '1;
            run_active  <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            step_cnt    <= step_cnt_nxt;
            rst_out     <= rst_out_nxt;
            run_active  <= run_active_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            cycle_count <= cycle_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        step_cnt_nxt    = step_cnt;
        rst_out_nxt     = rst_out;
        run_active_nxt  = run_active;
        done_nxt        = done;
        timeout_nxt     = timeout;
        cycle_count_nxt = cycle_count;

        case (state)
            ASSERT: begin
                if (rst_sync) begin
                    if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        rst_out_nxt  = (STEP_CYCLES == 0) ? '0 : (rst_out << 1);
                        step_cnt_nxt = '0;
                        state_nxt    = RELEASE;
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            RELEASE: begin
                // Shifting a zero in from bit 0 releases channels strictly in index order.
                if (rst_out == '0) begin
                    state_nxt       = RUN;
                    run_active_nxt  = 1'b1;
                    cycle_count_nxt = '0;
                end else if (step_cnt == STEP_W'(STEP_LAST)) begin
                    rst_out_nxt  = rst_out << 1;
                    step_cnt_nxt = '0;
                end else begin
                    step_cnt_nxt = step_cnt + STEP_W'(1);
                end
            end
            RUN: begin
                if (halt) begin
                    state_nxt      = DONE;
                    run_active_nxt = 1'b0;
                    done_nxt       = 1'b1;
                    timeout_nxt    = 1'b0;
                end else begin
                    cycle_count_nxt = cnt_inc;
                    if (MAX_CYCLES != 0 && cnt_inc == CNT_W'(MAX_CYCLES)) begin
                        state_nxt      = DONE;
                        run_active_nxt = 1'b0;
                        done_nxt       = 1'b1;
                        timeout_nxt    = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Restart keeps rst_sync, so the re-run skips the synchroniser delay.
        if (restart && !(state == ASSERT && !rst_sync)) begin
            state_nxt       = ASSERT;
            hold_cnt_nxt    = '0;
            step_cnt_nxt    = '0;
            rst_out_nxt     = '1;
            run_active_nxt  = 1'b0;
            done_nxt        = 1'b0;
            timeout_nxt     = 1'b0;
            cycle_count_nxt = '0;
        end
    end
endmodule
